// File: rtl/btn_event_classifier.sv
// Classifies debounced button presses as short, long or double-click and reports the last hold length.
// Optional auto-repeat in the long-press state is built when BTN_AUTOREPEAT_EN is defined.
module btn_event_classifier #(
  parameter int LONG_MS   = 20,
  parameter int DCLICK_MS = 10,
  parameter int REPEAT_MS = 5,
  parameter int CNT_W     = 12
) (
  input  logic             clk_1Khz,
  input  logic             rst,
  input  logic             data_in,
  input  logic             valid_in,
  output logic             short_press_o,
  output logic             long_press_o,
  output logic             double_click_o,
  output logic             repeat_o,
  output logic             held_o,
  output logic [CNT_W-1:0] hold_ms_o
);

  localparam logic [CNT_W-1:0] LONG_C   = CNT_W'(LONG_MS);
  localparam logic [CNT_W-1:0] DCLICK_C = CNT_W'(DCLICK_MS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_GAP,
    S_PRESS2,
    S_LONG
  } state_t;

  state_t           state_q, state_d;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] hold_ms_q, hold_ms_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] gap_inc;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             dclick_q, dclick_d;
  logic             press_w, rel_w;

  // Edges are judged between the held sample and the sample about to be taken.
  always_comb begin
    lvl_d   = valid_in ? data_in : lvl_q;
    press_w = !lvl_q && lvl_d;
    rel_w   = lvl_q && !lvl_d;
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_ms_d  = hold_ms_q;
    if (press_w) begin
      hold_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (lvl_q && lvl_d && (hold_cnt_q != CNT_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
    if (rel_w) begin
      hold_ms_d = hold_cnt_q;
    end
  end

  assign gap_inc = (gap_cnt_q == CNT_MAX) ? gap_cnt_q : gap_cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_inc;
    short_d   = 1'b0;
    long_d    = 1'b0;
    dclick_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press_w) state_d = S_PRESS1;
      end
      S_PRESS1: begin
        if (rel_w) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end else if (lvl_d && (hold_cnt_q >= LONG_C)) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end
      end
      S_GAP: begin
        // A press landing on the timeout cycle still wins over the short press.
        if (press_w) begin
          state_d = S_PRESS2;
        end else if (gap_inc >= DCLICK_C) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end
      S_PRESS2: begin
        if (rel_w) begin
          state_d  = S_IDLE;
          dclick_d = 1'b1;
        end else if (lvl_d && (hold_cnt_q >= LONG_C)) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end
      end
      S_LONG: begin
        if (rel_w) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_1Khz) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lvl_q      <= 1'b0;
      hold_cnt_q <= '0;
      hold_ms_q  <= '0;
      gap_cnt_q  <= '0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      dclick_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      hold_cnt_q <= hold_cnt_d;
      hold_ms_q  <= hold_ms_d;
      gap_cnt_q  <= gap_cnt_d;
      short_q    <= short_d;
      long_q     <= long_d;
      dclick_q   <= dclick_d;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_MS);

  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] rep_inc;
  logic             rep_q, rep_d;

  assign rep_inc = (rep_cnt_q == CNT_MAX) ? rep_cnt_q : rep_cnt_q + 1'b1;

  // Counter sits at zero outside LONG, so every entry restarts the period.
  always_comb begin
    rep_cnt_d = '0;
    rep_d     = 1'b0;
    if ((state_q == S_LONG) && (state_d == S_LONG)) begin
      if (rep_inc >= REPEAT_C) begin
        rep_d = 1'b1;
      end else begin
        rep_cnt_d = rep_inc;
      end
    end
  end

  always_ff @(posedge clk_1Khz) begin
    if (rst) begin
      rep_cnt_q <= '0;
      rep_q     <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_q     <= rep_d;
    end
  end

  assign repeat_o = rep_q;
`else
  assign repeat_o = 1'b0;
`endif

  assign short_press_o  = short_q;
  assign long_press_o   = long_q;
  assign double_click_o = dclick_q;
  assign held_o         = lvl_q;
  assign hold_ms_o      = hold_ms_q;

endmodule

// File: tb/tb_btn_event_classifier.sv
// Scoreboard bench for btn_event_classifier: expected pulses queued with their cycle, observed pulses compared per scenario.
module tb_btn_event_classifier;

  localparam int LONG_MS   = 20;
  localparam int DCLICK_MS = 10;
  localparam int REPEAT_MS = 5;
  localparam int CNT_W     = 12;

  localparam int K_SHORT  = 1;
  localparam int K_LONG   = 2;
  localparam int K_DCLICK = 3;
  localparam int K_REPEAT = 4;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic             clk_1Khz = 1'b0;
  logic             rst      = 1'b1;
  logic             data_in  = 1'b0;
  logic             valid_in = 1'b1;
  logic             short_press_o, long_press_o, double_click_o, repeat_o, held_o;
  logic [CNT_W-1:0] hold_ms_o;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always #5 clk_1Khz = ~clk_1Khz;

  btn_event_classifier #(
    .LONG_MS  (LONG_MS),
    .DCLICK_MS(DCLICK_MS),
    .REPEAT_MS(REPEAT_MS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_1Khz      (clk_1Khz),
    .rst           (rst),
    .data_in       (data_in),
    .valid_in      (valid_in),
    .short_press_o (short_press_o),
    .long_press_o  (long_press_o),
    .double_click_o(double_click_o),
    .repeat_o      (repeat_o),
    .held_o        (held_o),
    .hold_ms_o     (hold_ms_o)
  );

  // One clock edge of stimulus; records every pulse seen just after the edge.
  task automatic step(input logic d, input logic v, input logic r);
    ev_t e;
    data_in  = d;
    valid_in = v;
    rst      = r;
    @(posedge clk_1Khz);
    #1;
    cyc++;
    e.cyc = cyc;
    if (short_press_o === 1'b1)  begin e.kind = K_SHORT;  obs_q.push_back(e); $display("cyc %0d short_press", cyc); end
    if (long_press_o === 1'b1)   begin e.kind = K_LONG;   obs_q.push_back(e); $display("cyc %0d long_press", cyc); end
    if (double_click_o === 1'b1) begin e.kind = K_DCLICK; obs_q.push_back(e); $display("cyc %0d double_click", cyc); end
    if (repeat_o === 1'b1)       begin e.kind = K_REPEAT; obs_q.push_back(e); $display("cyc %0d repeat", cyc); end
  endtask

  task automatic push_exp(input int c, input int k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    exp_q.delete(); obs_q.delete();
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if ({short_press_o, long_press_o, double_click_o, repeat_o, held_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b want 00000", {short_press_o, long_press_o, double_click_o, repeat_o, held_o});
    end
    checks++;
    if (hold_ms_o !== '0) begin
      errors++;
      $display("FAIL reset_hold_ms got %0d want 0", hold_ms_o);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL reset_no_events got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_short_press;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    push_exp(cyc + 1 + DCLICK_MS, K_SHORT);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL short_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc || o.kind !== e.kind) begin
        errors++;
        $display("FAIL short_event got kind %0d cyc %0d want kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    checks++;
    if (hold_ms_o !== CNT_W'(5)) begin
      errors++;
      $display("FAIL short_hold_ms got %0d want 5", hold_ms_o);
    end
  endtask

  task automatic test_double_click;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    push_exp(cyc + 1, K_DCLICK);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL dclick_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc || o.kind !== e.kind) begin
        errors++;
        $display("FAIL dclick_event got kind %0d cyc %0d want kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    checks++;
    if (hold_ms_o !== CNT_W'(4)) begin
      errors++;
      $display("FAIL dclick_hold_ms got %0d want 4", hold_ms_o);
    end
  endtask

  task automatic test_gap_boundary;
    ev_t e, o;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < DCLICK_MS; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    push_exp(cyc + 1, K_DCLICK);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL gapedge_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc || o.kind !== e.kind) begin
        errors++;
        $display("FAIL gapedge_event got kind %0d cyc %0d want kind %0d cyc %0d", o.kind, o.cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic test_long_press(input int hold_len, input string tag);
    ev_t e, o;
    int  p;
    exp_q.delete(); obs_q.delete();
    p = cyc + 1;
    push_exp(p + LONG_MS, K_LONG);
`ifdef BTN_AUTOREPEAT_EN
    for (int t = LONG_MS + REPEAT_MS; t < hold_len; t += REPEAT_MS) push_exp(p + t, K_REPEAT);
`endif
    for (int i = 0; i < hold_len; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", tag, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++;
      if (o.cyc !== e.cyc || o.kind !== e.kind) begin
        errors++;
        $display("FAIL %s_event got kind %0d cyc %0d want kind %0d cyc %0d", tag, o.kind, o.cyc, e.kind, e.cyc);
      end
    end
    checks++;
    if (hold_ms_o !== CNT_W'(hold_len)) begin
      errors++;
      $display("FAIL %s_hold_ms got %0d want %0d", tag, hold_ms_o, hold_len);
    end
  endtask

  task automatic test_qualifier;
    logic moved;
    exp_q.delete(); obs_q.delete();
    moved = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(logic'(i % 2 == 0), 1'b0, 1'b0);
      if (held_o !== 1'b0) moved = 1'b1;
    end
    checks++;
    if (moved !== 1'b0) begin
      errors++;
      $display("FAIL qual_held got %b want 0", moved);
    end
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL qual_no_events got %0d want 0", obs_q.size());
    end
  endtask

  task automatic test_reset_in_gap;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    checks++;
    if ({short_press_o, long_press_o, double_click_o, repeat_o, held_o} !== 5'b0 || hold_ms_o !== '0) begin
      errors++;
      $display("FAIL gaprst_outputs got %b/%0d want 00000/0",
               {short_press_o, long_press_o, double_click_o, repeat_o, held_o}, hold_ms_o);
    end
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL gaprst_no_short got %0d want 0", obs_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_short_press;
    test_double_click;
    test_gap_boundary;
    test_long_press(30, "long30");
    test_qualifier;
    test_reset_in_gap;
    test_long_press(36, "long36");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
